// File: rtl/program_counter_stack_pkg.sv
// Shared opcode definitions for the tau fetch-stage program counter.
// Optional build macro PC_STACK_GUARD_EN is consumed by program_counter_stack.
package pc_pkg;

    localparam int PC_OP_W = 3;

    // Encodings 6 and 7 are reserved and execute as HOLD.
    typedef enum logic [PC_OP_W-1:0] {
        OP_HOLD   = 3'd0,
        OP_INC    = 3'd1,
        OP_LOAD   = 3'd2,
        OP_BRANCH = 3'd3,
        OP_CALL   = 3'd4,
        OP_RET    = 3'd5
    } pc_op_t;

    // Width of an occupancy counter that must represent 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/program_counter_stack_if.sv
// Control/status bundle between the fetch sequencer (master) and the program counter (slave).
interface program_counter_stack_if
    import pc_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 16,
    parameter int STACK_DEPTH   = 8
);

    localparam int DEPTH_W = count_width(STACK_DEPTH);

    logic                     enable;
    pc_op_t                   op;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [ADDRESS_WIDTH-1:0] offset;
    logic [ADDRESS_WIDTH-1:0] data;
    logic [ADDRESS_WIDTH-1:0] return_address;
    logic [DEPTH_W-1:0]       depth;
    logic                     stack_empty;
    logic                     stack_full;
    logic                     fault;

    modport master (
        output enable, op, address, offset,
        input  data, return_address, depth, stack_empty, stack_full, fault
    );

    modport slave (
        input  enable, op, address, offset,
        output data, return_address, depth, stack_empty, stack_full, fault
    );

endinterface

// File: rtl/program_counter_stack_return_stack.sv
// Return-address LIFO with a circular write pointer: a push while full overwrites
// the oldest entry; overflow/underflow policy belongs to the parent.
module return_stack
    import pc_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             top,
    output logic [count_width(DEPTH)-1:0] depth,
    output logic                         full,
    output logic                         empty
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int DEPTH_W = count_width(DEPTH);

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   top_ptr;
    logic [DEPTH_W-1:0] count;

    // NOTE: the storage array has no reset; stale entries are never visible
    // because top is masked while count is zero, and skipping the reset lets
    // the array map onto plain RAM cells.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // NOTE: state registers use non-blocking assignments so every always_ff
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
            if (!full) begin
                count <= count + DEPTH_W'(1);
            end
        end else if (pop && !empty) begin
            wr_ptr <= wr_ptr - PTR_W'(1);
            count  <= count - DEPTH_W'(1);
        end
    end

    // The pointer wraps modulo DEPTH, so the newest entry always sits just below it.
    assign top_ptr = wr_ptr - PTR_W'(1);
    assign empty   = (count == '0);
    assign full    = (count == DEPTH_W'(DEPTH));
    assign depth   = count;
    assign top     = empty ? '0 : mem[top_ptr];

endmodule

// File: rtl/program_counter_stack.sv
// Fetch-stage program counter with increment, load, relative branch and call/return.
// Define PC_STACK_GUARD_EN to drop overflowing CALLs / underflowing RETs and raise a sticky fault.
module program_counter_stack
    import pc_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 16,
    parameter int STACK_DEPTH   = 8,
    parameter int STEP          = 1,
    parameter int RESET_VECTOR  = 0
) (
    input  logic                    clock,
    input  logic                    reset,
    program_counter_stack_if.slave  bus
);

    localparam int                       DEPTH_W  = count_width(STACK_DEPTH);
    localparam logic [ADDRESS_WIDTH-1:0] STEP_W   = ADDRESS_WIDTH'(STEP);
    localparam logic [ADDRESS_WIDTH-1:0] RESET_PC = ADDRESS_WIDTH'(RESET_VECTOR);

    logic [ADDRESS_WIDTH-1:0] pc_q;
    logic [ADDRESS_WIDTH-1:0] pc_d;
    logic [ADDRESS_WIDTH-1:0] pc_seq;
    logic [ADDRESS_WIDTH-1:0] stk_top;
    logic [DEPTH_W-1:0]       stk_depth;
    logic                     stk_full;
    logic                     stk_empty;
    logic                     push;
    logic                     pop;
`ifdef PC_STACK_GUARD_EN
    logic                     fault_set;
    logic                     fault_q;
`endif

    assign pc_seq = pc_q + STEP_W;

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        pc_d = pc_q;
        push = 1'b0;
        pop  = 1'b0;
`ifdef PC_STACK_GUARD_EN
        fault_set = 1'b0;
`endif
        if (bus.enable) begin
            case (bus.op)
                OP_INC:    pc_d = pc_seq;
                OP_LOAD:   pc_d = bus.address;
                OP_BRANCH: pc_d = pc_q + bus.offset;
                OP_CALL: begin
`ifdef PC_STACK_GUARD_EN
                    if (stk_full) begin
                        fault_set = 1'b1;
                    end else begin
                        push = 1'b1;
                        pc_d = bus.address;
                    end
`else
                    push = 1'b1;
                    pc_d = bus.address;
`endif
                end
                OP_RET: begin
                    if (stk_empty) begin
`ifdef PC_STACK_GUARD_EN
                        fault_set = 1'b1;
`else
                        pc_d = pc_seq;
`endif
                    end else begin
                        pop  = 1'b1;
                        pc_d = stk_top;
                    end
                end
                default: pc_d = pc_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

`ifdef PC_STACK_GUARD_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            fault_q <= 1'b0;
        end else if (fault_set) begin
            fault_q <= 1'b1;
        end
    end

    assign bus.fault = fault_q;
`else
    assign bus.fault = 1'b0;
`endif

    // Reset outranks any op, so a CALL issued during reset must not touch the RAM.
    return_stack #(
        .WIDTH (ADDRESS_WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_return_stack (
        .clock (clock),
        .reset (reset),
        .push  (push && !reset),
        .pop   (pop),
        .wdata (pc_seq),
        .top   (stk_top),
        .depth (stk_depth),
        .full  (stk_full),
        .empty (stk_empty)
    );

    assign bus.data           = pc_q;
    assign bus.return_address = stk_top;
    assign bus.depth          = stk_depth;
    assign bus.stack_empty    = stk_empty;
    assign bus.stack_full     = stk_full;

endmodule

// File: tb/tb_program_counter_stack.sv
// Self-checking bench: directed vector table, stack overflow/underflow sequences,
// then randomized ops against a queue-based reference model.
module tb_program_counter_stack;
    import pc_pkg::*;

    localparam int AW    = 16;
    localparam int DEPTH = 8;

    typedef struct {
        logic        en;
        logic [2:0]  op;
        logic [15:0] addr;
        logic [15:0] off;
        logic [15:0] exp_data;
        int          exp_depth;
        logic [15:0] exp_ra;
    } vec_t;

    logic clock;
    logic reset;

    program_counter_stack_if #(.ADDRESS_WIDTH(AW), .STACK_DEPTH(DEPTH)) bus ();

    program_counter_stack #(
        .ADDRESS_WIDTH (AW),
        .STACK_DEPTH   (DEPTH),
        .STEP          (1),
        .RESET_VECTOR  (16'h0100)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: pc plus a queue whose back is the top of the stack.
    logic [15:0] m_pc;
    logic [15:0] m_stk [$];
    logic        m_fault;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic en, input logic [2:0] op,
                              input logic [15:0] addr, input logic [15:0] off);
        if (r) begin
            m_pc = 16'h0100;
            m_stk.delete();
            m_fault = 1'b0;
        end else if (en) begin
            case (op)
                3'd1: m_pc = m_pc + 16'd1;
                3'd2: m_pc = addr;
                3'd3: m_pc = m_pc + off;
                3'd4: begin
                    if (m_stk.size() == DEPTH) begin
`ifdef PC_STACK_GUARD_EN
                        m_fault = 1'b1;
`else
                        void'(m_stk.pop_front());
                        m_stk.push_back(m_pc + 16'd1);
                        m_pc = addr;
`endif
                    end else begin
                        m_stk.push_back(m_pc + 16'd1);
                        m_pc = addr;
                    end
                end
                3'd5: begin
                    if (m_stk.size() == 0) begin
`ifdef PC_STACK_GUARD_EN
                        m_fault = 1'b1;
`else
                        m_pc = m_pc + 16'd1;
`endif
                    end else begin
                        m_pc = m_stk.pop_back();
                    end
                end
                default: ;
            endcase
        end
    endtask

    // Drive one cycle's inputs, clock once, then settle away from the edge.
    task automatic tick(input logic r, input logic en, input logic [2:0] op,
                        input logic [15:0] addr, input logic [15:0] off);
        reset       = r;
        bus.enable  = en;
        bus.op      = pc_op_t'(op);
        bus.address = addr;
        bus.offset  = off;
        model_step(r, en, op, addr, off);
        @(posedge clock);
        #1;
    endtask

    task automatic check_model();
        logic [15:0] ra;
        ra = (m_stk.size() == 0) ? 16'h0000 : m_stk[m_stk.size() - 1];
        check("rand_data",  32'(bus.data), 32'(m_pc));
        check("rand_depth", 32'(bus.depth), 32'(m_stk.size()));
        check("rand_ra",    32'(bus.return_address), 32'(ra));
        check("rand_empty", 32'(bus.stack_empty), 32'(m_stk.size() == 0));
        check("rand_full",  32'(bus.stack_full), 32'(m_stk.size() == DEPTH));
        check("rand_fault", 32'(bus.fault), 32'(m_fault));
    endtask

    vec_t        vecs [16];
    logic [15:0] rets [9];

    initial begin
        reset       = 1'b1;
        bus.enable  = 1'b0;
        bus.op      = OP_HOLD;
        bus.address = '0;
        bus.offset  = '0;
        m_pc        = 16'h0100;
        m_fault     = 1'b0;

        vecs[0]  = '{1'b1, 3'd1, 16'h0000, 16'h0000, 16'h0101, 0, 16'h0000};
        vecs[1]  = '{1'b1, 3'd1, 16'h0000, 16'h0000, 16'h0102, 0, 16'h0000};
        vecs[2]  = '{1'b1, 3'd1, 16'h0000, 16'h0000, 16'h0103, 0, 16'h0000};
        vecs[3]  = '{1'b1, 3'd2, 16'hFFFF, 16'h0000, 16'hFFFF, 0, 16'h0000};
        vecs[4]  = '{1'b1, 3'd1, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000};
        vecs[5]  = '{1'b1, 3'd2, 16'h0040, 16'h0000, 16'h0040, 0, 16'h0000};
        vecs[6]  = '{1'b1, 3'd3, 16'h0000, 16'hFFF0, 16'h0030, 0, 16'h0000};
        vecs[7]  = '{1'b1, 3'd3, 16'h0000, 16'h0010, 16'h0040, 0, 16'h0000};
        vecs[8]  = '{1'b1, 3'd2, 16'h0010, 16'h0000, 16'h0010, 0, 16'h0000};
        vecs[9]  = '{1'b1, 3'd4, 16'h0200, 16'h0000, 16'h0200, 1, 16'h0011};
        vecs[10] = '{1'b1, 3'd5, 16'h0000, 16'h0000, 16'h0011, 0, 16'h0000};
        vecs[11] = '{1'b0, 3'd1, 16'h0000, 16'h0000, 16'h0011, 0, 16'h0000};
        vecs[12] = '{1'b1, 3'd0, 16'h1234, 16'h0000, 16'h0011, 0, 16'h0000};
        vecs[13] = '{1'b1, 3'd6, 16'h1234, 16'h0004, 16'h0011, 0, 16'h0000};
        vecs[14] = '{1'b1, 3'd4, 16'h0300, 16'h0000, 16'h0300, 1, 16'h0012};
        vecs[15] = '{1'b1, 3'd5, 16'h0000, 16'h0000, 16'h0012, 0, 16'h0000};

        // Reset values.
        tick(1'b1, 1'b1, 3'd1, 16'h0000, 16'h0000);
        check("reset_data",  32'(bus.data), 32'h0100);
        check("reset_depth", 32'(bus.depth), 32'd0);
        check("reset_fault", 32'(bus.fault), 32'd0);
        check("reset_empty", 32'(bus.stack_empty), 32'd1);
        check("reset_ra",    32'(bus.return_address), 32'd0);

        foreach (vecs[i]) begin
            tick(1'b0, vecs[i].en, vecs[i].op, vecs[i].addr, vecs[i].off);
            check($sformatf("vec%0d_data", i),  32'(bus.data), 32'(vecs[i].exp_data));
            check($sformatf("vec%0d_depth", i), 32'(bus.depth), 32'(vecs[i].exp_depth));
            check($sformatf("vec%0d_ra", i),    32'(bus.return_address), 32'(vecs[i].exp_ra));
            check($sformatf("vec%0d_empty", i), 32'(bus.stack_empty), 32'(vecs[i].exp_depth == 0));
            check($sformatf("vec%0d_fault", i), 32'(bus.fault), 32'd0);
        end

        // Overflow: STACK_DEPTH+1 CALLs from a known pc.
        tick(1'b1, 1'b0, 3'd0, 16'h0000, 16'h0000);
        tick(1'b0, 1'b1, 3'd2, 16'h1000, 16'h0000);
        rets[0] = 16'h1001;
        for (int i = 1; i < 9; i++) begin
            rets[i] = 16'h2000 + 16'((i - 1) * 16) + 16'h0001;
        end
        for (int i = 0; i < 9; i++) begin
            tick(1'b0, 1'b1, 3'd4, 16'h2000 + 16'(i * 16), 16'h0000);
        end
        check("ovf_depth", 32'(bus.depth), 32'd8);
        check("ovf_full",  32'(bus.stack_full), 32'd1);
`ifdef PC_STACK_GUARD_EN
        check("ovf_data",  32'(bus.data), 32'h2070);
        check("ovf_fault", 32'(bus.fault), 32'd1);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("ovf_ra%0d", k), 32'(bus.return_address), 32'(rets[7 - k]));
            tick(1'b0, 1'b1, 3'd5, 16'h0000, 16'h0000);
            check($sformatf("ovf_ret%0d", k), 32'(bus.data), 32'(rets[7 - k]));
        end
        tick(1'b0, 1'b1, 3'd5, 16'h0000, 16'h0000);
        check("unf_data",  32'(bus.data), 32'(rets[0]));
        check("unf_fault", 32'(bus.fault), 32'd1);
`else
        check("ovf_data",  32'(bus.data), 32'h2080);
        check("ovf_fault", 32'(bus.fault), 32'd0);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("ovf_ra%0d", k), 32'(bus.return_address), 32'(rets[8 - k]));
            tick(1'b0, 1'b1, 3'd5, 16'h0000, 16'h0000);
            check($sformatf("ovf_ret%0d", k), 32'(bus.data), 32'(rets[8 - k]));
        end
        tick(1'b0, 1'b1, 3'd5, 16'h0000, 16'h0000);
        check("unf_data",  32'(bus.data), 32'(rets[1] + 16'h0001));
        check("unf_fault", 32'(bus.fault), 32'd0);
`endif
        check("unf_depth", 32'(bus.depth), 32'd0);
        check("unf_empty", 32'(bus.stack_empty), 32'd1);

        // Reset outranks a simultaneous CALL.
        tick(1'b0, 1'b1, 3'd4, 16'h4000, 16'h0000);
        tick(1'b1, 1'b1, 3'd4, 16'h5555, 16'h0000);
        check("rstcall_data",  32'(bus.data), 32'h0100);
        check("rstcall_depth", 32'(bus.depth), 32'd0);
        check("rstcall_fault", 32'(bus.fault), 32'd0);

        // Randomized ops against the reference model.
        for (int n = 0; n < 3000; n++) begin
            tick(($urandom_range(0, 255) == 0), ($urandom_range(0, 7) != 0),
                 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));
            check_model();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fails);
        $finish;
    end

endmodule
